// File: rtl/sht40_sequencer.sv
// SHT40 measurement sequencer: drives an upstream I2C master through measure-command write,
// conversion wait, 6-byte read and CRC check, then publishes the raw temperature/humidity words.
//
// state   | meaning
// IDLE    | waiting for start
// WR_GO   | launch 1-byte write of the measure command
// WR_WAIT | wait for write completion or timeout
// CONV    | conversion wait before reading
// RD_GO   | launch 6-byte read
// RD_WAIT | collect bytes, wait for read completion or timeout
// CHECK   | verify both CRC-8 fields and publish result
module sht40_sequencer #(
   parameter logic [6:0] SHT_ADDR      = 7'h44,
   parameter logic [7:0] MEAS_CMD      = 8'hFD,
   parameter int         MEAS_WAIT_CYC = 20000,
   parameter int         TIMEOUT_CYC   = 4000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [2:0]  err_code,
   output logic        data_valid,
   output logic [15:0] temp_raw,
   output logic [15:0] rh_raw,
   output logic        i2c_start,
   output logic [6:0]  i2c_addr,
   output logic        i2c_rw,
   output logic [3:0]  i2c_num_bytes,
   output logic [7:0]  i2c_tx_byte,
   input  logic        i2c_rx_valid,
   input  logic [7:0]  i2c_rx_byte,
   input  logic        i2c_done,
   input  logic        i2c_nack
);
   localparam int TMR_MAX = (MEAS_WAIT_CYC > TIMEOUT_CYC) ? MEAS_WAIT_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   // Loads chosen so done lands exactly TIMEOUT_CYC after i2c_start, and the read launches
   // exactly MEAS_WAIT_CYC cycles after the write completes.
   localparam logic [TMR_W-1:0] CONV_LOAD = TMR_W'(MEAS_WAIT_CYC - 1);
   localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT_CYC - 2);

   localparam logic [2:0] ERR_OK    = 3'd0;
   localparam logic [2:0] ERR_NACK  = 3'd1;
   localparam logic [2:0] ERR_TCRC  = 3'd2;
   localparam logic [2:0] ERR_RHCRC = 3'd3;
   localparam logic [2:0] ERR_SHORT = 3'd4;
   localparam logic [2:0] ERR_TMO   = 3'd5;

   typedef enum logic [2:0] {IDLE, WR_GO, WR_WAIT, CONV, RD_GO, RD_WAIT, CHECK} state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       rx_buf [6];
   logic             rx_take;
   logic             fin;
   logic [2:0]       fin_err;
   logic [7:0]       t_crc, rh_crc;

   function automatic logic [7:0] crc8(input logic [7:0] msb, input logic [7:0] lsb);
      logic [15:0] data;
      logic [7:0]  crc;
      logic        fb;
      data = {msb, lsb};
      crc  = 8'hFF;
      for (int i = 15; i >= 0; i--) begin
         fb  = crc[7] ^ data[i];
         crc = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
      end
      return crc;
   endfunction

   assign t_crc   = crc8(rx_buf[0], rx_buf[1]);
   assign rh_crc  = crc8(rx_buf[3], rx_buf[4]);
   assign rx_take = (state == RD_WAIT) && i2c_rx_valid && (idx < 3'd6);

   assign busy          = (state != IDLE);
   assign i2c_start     = (state == WR_GO) || (state == RD_GO);
   assign i2c_addr      = SHT_ADDR;
   assign i2c_rw        = (state == RD_GO) || (state == RD_WAIT);
   assign i2c_num_bytes = i2c_rw ? 4'd6 : (((state == WR_GO) || (state == WR_WAIT)) ? 4'd1 : 4'd0);
   assign i2c_tx_byte   = ((state == WR_GO) || (state == WR_WAIT)) ? MEAS_CMD : 8'h00;

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      idx_nxt   = idx;
      fin       = 1'b0;
      fin_err   = ERR_OK;
      case (state)
         IDLE: if (start) state_nxt = WR_GO;
         WR_GO: begin
            state_nxt = WR_WAIT;
            tmr_nxt   = TMO_LOAD;
         end
         WR_WAIT: begin
            if (i2c_done) begin
               if (i2c_nack) begin
                  fin     = 1'b1;
                  fin_err = ERR_NACK;
               end else begin
                  state_nxt = CONV;
                  tmr_nxt   = CONV_LOAD;
               end
            end else if (tmr == '0) begin
               fin     = 1'b1;
               fin_err = ERR_TMO;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         CONV: begin
            if (tmr == '0) state_nxt = RD_GO;
            else           tmr_nxt   = tmr - 1'b1;
         end
         RD_GO: begin
            state_nxt = RD_WAIT;
            tmr_nxt   = TMO_LOAD;
            idx_nxt   = 3'd0;
         end
         RD_WAIT: begin
            // A byte arriving with i2c_done counts toward the length check.
            if (rx_take) idx_nxt = idx + 3'd1;
            if (i2c_done) begin
               if (i2c_nack) begin
                  fin     = 1'b1;
                  fin_err = ERR_NACK;
               end else if (idx_nxt < 3'd6) begin
                  fin     = 1'b1;
                  fin_err = ERR_SHORT;
               end else begin
                  state_nxt = CHECK;
               end
            end else if (tmr == '0) begin
               fin     = 1'b1;
               fin_err = ERR_TMO;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         CHECK: begin
            fin = 1'b1;
            if (t_crc != rx_buf[2])       fin_err = ERR_TCRC;
            else if (rh_crc != rx_buf[5]) fin_err = ERR_RHCRC;
            else                          fin_err = ERR_OK;
         end
         default: state_nxt = IDLE;
      endcase
      if (fin) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         tmr        <= '0;
         idx        <= 3'd0;
         done       <= 1'b0;
         data_valid <= 1'b0;
         err_code   <= ERR_OK;
         temp_raw   <= 16'h0000;
         rh_raw     <= 16'h0000;
         for (int i = 0; i < 6; i++) rx_buf[i] <= 8'h00;
      end else begin
         state      <= state_nxt;
         tmr        <= tmr_nxt;
         idx        <= idx_nxt;
         done       <= fin;
         data_valid <= fin && (fin_err == ERR_OK);
         if (fin) err_code <= fin_err;
         if (fin && (fin_err == ERR_OK)) begin
            temp_raw <= {rx_buf[0], rx_buf[1]};
            rh_raw   <= {rx_buf[3], rx_buf[4]};
         end
         if (rx_take) rx_buf[idx] <= i2c_rx_byte;
      end
   end
endmodule

// File: tb/tb_sht40_sequencer.sv
// Bench for sht40_sequencer: a driver plays the I2C master per scenario and queues the expected
// result; a monitor pops and compares on every done pulse.
module tb_sht40_sequencer;
   localparam int M = 40;
   localparam int T = 60;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, data_valid, i2c_start, i2c_rw;
   logic [2:0]  err_code;
   logic [15:0] temp_raw, rh_raw;
   logic [6:0]  i2c_addr;
   logic [3:0]  i2c_num_bytes;
   logic [7:0]  i2c_tx_byte;
   logic        i2c_rx_valid = 1'b0;
   logic [7:0]  i2c_rx_byte = 8'h00;
   logic        i2c_done = 1'b0;
   logic        i2c_nack = 1'b0;

   sht40_sequencer #(.MEAS_WAIT_CYC(M), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .err_code(err_code), .data_valid(data_valid), .temp_raw(temp_raw), .rh_raw(rh_raw),
      .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
      .i2c_num_bytes(i2c_num_bytes), .i2c_tx_byte(i2c_tx_byte),
      .i2c_rx_valid(i2c_rx_valid), .i2c_rx_byte(i2c_rx_byte),
      .i2c_done(i2c_done), .i2c_nack(i2c_nack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit             wr_nack, wr_hold, rd_nack, rd_hold, same_cyc, busy_poke;
      int             wr_dly;
      int             n_rx;
      logic [6:0][7:0] b;
   } scn_t;

   typedef struct packed {
      logic [2:0]  err;
      logic        dv;
      logic [15:0] t, h;
   } exp_t;

   int   cyc = 0;
   int   pulses = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q [$];
   int   cyc_q [$];
   logic [15:0] last_t = 16'h0, last_h = 16'h0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (i2c_start) pulses++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_msg(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: expected DUT event did not occur within bound (cycle %0d)", name, cyc);
   endtask

   // Byte-at-a-time CRC-8, poly 0x31, init 0xFF.
   function automatic logic [7:0] ref_crc(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] c;
      logic [7:0] m [2];
      c = 8'hFF; m[0] = a; m[1] = b;
      for (int j = 0; j < 2; j++) begin
         c = c ^ m[j];
         for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [2:0] model_err(input scn_t s);
      if (s.wr_hold) return 3'd5;
      if (s.wr_nack) return 3'd1;
      if (s.rd_hold) return 3'd5;
      if (s.rd_nack) return 3'd1;
      if (s.n_rx < 6) return 3'd4;
      if (ref_crc(s.b[0], s.b[1]) != s.b[2]) return 3'd2;
      if (ref_crc(s.b[3], s.b[4]) != s.b[5]) return 3'd3;
      return 3'd0;
   endfunction

   function automatic scn_t good(input logic [15:0] t, input logic [15:0] h);
      scn_t s;
      s = '0;
      s.wr_dly = 3;
      s.n_rx = 6;
      s.b[0] = t[15:8]; s.b[1] = t[7:0]; s.b[2] = ref_crc(t[15:8], t[7:0]);
      s.b[3] = h[15:8]; s.b[4] = h[7:0]; s.b[5] = ref_crc(h[15:8], h[7:0]);
      s.b[6] = 8'h5A;
      return s;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            fail_msg("unexpected_done");
         end else begin
            e = exp_q.pop_front();
            chk("err_code", {29'd0, err_code}, {29'd0, e.err});
            chk("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
            chk("temp_raw", {16'd0, temp_raw}, {16'd0, e.t});
            chk("rh_raw", {16'd0, rh_raw}, {16'd0, e.h});
            if (cyc_q.size() == 0) fail_msg("done_cycle_unscheduled");
            else chk("done_cycle", cyc, cyc_q.pop_front());
         end
      end
   end

   task automatic recover();
      start = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rx_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); cyc_q.delete();
      last_t = 16'h0; last_h = 16'h0;
   endtask

   task automatic wait_istart(input int lim, output int t, output bit ok);
      ok = 1'b0; t = 0;
      for (int i = 0; i < lim; i++) begin
         if (i2c_start) begin ok = 1'b1; t = cyc; break; end
         @(negedge clk);
      end
   endtask

   task automatic run_txn(input scn_t s);
      exp_t e;
      int   c_s, t0, w, r0, d, p0, exp_pulses;
      bit   ok, sent, fast_end;
      e.err = model_err(s);
      if (e.err == 3'd0) begin last_t = {s.b[0], s.b[1]}; last_h = {s.b[3], s.b[4]}; end
      e.dv = (e.err == 3'd0);
      e.t = last_t; e.h = last_h;
      exp_q.push_back(e);
      exp_pulses = (s.wr_hold || s.wr_nack) ? 1 : 2;
      fast_end = s.rd_nack || (s.n_rx < 6);
      w = 0; p0 = pulses;
      @(negedge clk); start = 1'b1; c_s = cyc;
      @(negedge clk); start = 1'b0;
      wait_istart(4, t0, ok);
      if (!ok) begin fail_msg("wr_i2c_start"); recover(); return; end
      chk("start_latency", t0, c_s + 1);
      chk("busy", {31'd0, busy}, 1);
      chk("wr_rw", {31'd0, i2c_rw}, 0);
      chk("wr_nbytes", {28'd0, i2c_num_bytes}, 1);
      chk("wr_tx_byte", {24'd0, i2c_tx_byte}, 32'hFD);
      chk("i2c_addr", {25'd0, i2c_addr}, 32'h44);
      if (s.wr_hold) begin
         cyc_q.push_back(t0 + T);
      end else begin
         repeat (s.wr_dly) @(negedge clk);
         chk("wr_rw_held", {31'd0, i2c_rw}, 0);
         chk("wr_nbytes_held", {28'd0, i2c_num_bytes}, 1);
         i2c_done = 1'b1; i2c_nack = s.wr_nack; w = cyc;
         if (s.wr_nack) cyc_q.push_back(w + 1);
         @(negedge clk); i2c_done = 1'b0; i2c_nack = 1'b0;
         if (!s.wr_nack) begin
            if (s.busy_poke) begin
               repeat (3) @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
            wait_istart(M + 8, r0, ok);
            if (!ok) begin fail_msg("rd_i2c_start"); recover(); return; end
            chk("conv_gap", r0, w + M + 1);
            chk("rd_rw", {31'd0, i2c_rw}, 1);
            chk("rd_nbytes", {28'd0, i2c_num_bytes}, 6);
            chk("rd_tx_byte", {24'd0, i2c_tx_byte}, 0);
            if (s.rd_hold) cyc_q.push_back(r0 + T);
            sent = 1'b0;
            for (int i = 0; i < s.n_rx; i++) begin
               @(negedge clk);
               i2c_rx_valid = 1'b1; i2c_rx_byte = s.b[i];
               if (s.same_cyc && !s.rd_hold && i == s.n_rx - 1) begin
                  i2c_done = 1'b1; i2c_nack = s.rd_nack; d = cyc; sent = 1'b1;
                  cyc_q.push_back(fast_end ? d + 1 : c_s + (w - t0) + M + (d - r0) + 4);
               end
               @(negedge clk);
               i2c_rx_valid = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
            end
            if (!sent && !s.rd_hold) begin
               @(negedge clk);
               chk("rd_rw_held", {31'd0, i2c_rw}, 1);
               i2c_done = 1'b1; i2c_nack = s.rd_nack; d = cyc;
               cyc_q.push_back(fast_end ? d + 1 : c_s + (w - t0) + M + (d - r0) + 4);
               @(negedge clk);
               i2c_done = 1'b0; i2c_nack = 1'b0;
            end
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 2 * T + M + 40; i++) begin
         if (!busy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin fail_msg("return_to_idle"); recover(); return; end
      repeat (2) @(negedge clk);
      chk("idle_after_done", {31'd0, busy}, 0);
      chk("i2c_start_pulses", pulses - p0, exp_pulses);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic reset_mid_conv();
      int t0, p0;
      bit ok;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_istart(4, t0, ok);
      if (!ok) begin fail_msg("rst_wr_i2c_start"); recover(); return; end
      repeat (2) @(negedge clk);
      i2c_done = 1'b1;
      @(negedge clk); i2c_done = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_in_conv", {31'd0, busy}, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_err_code", {29'd0, err_code}, 0);
      chk("rst_temp_raw", {16'd0, temp_raw}, 0);
      chk("rst_rh_raw", {16'd0, rh_raw}, 0);
      chk("rst_i2c_start", {31'd0, i2c_start}, 0);
      chk("rst_nbytes", {28'd0, i2c_num_bytes}, 0);
      rst_n = 1'b1; p0 = pulses;
      last_t = 16'h0; last_h = 16'h0;
      @(negedge clk);
      chk("no_start_after_reset", {31'd0, i2c_start}, 0);
      repeat (M + 20) @(negedge clk);
      chk("no_resume_after_reset", pulses - p0, 0);
      chk("idle_after_reset", {31'd0, busy}, 0);
   endtask

   initial begin : watchdog
      #(10 * 40000);
      fail_msg("watchdog");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      scn_t s;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_done", {31'd0, done}, 0);
      chk("reset_data_valid", {31'd0, data_valid}, 0);
      chk("reset_err_code", {29'd0, err_code}, 0);
      chk("reset_temp_raw", {16'd0, temp_raw}, 0);
      chk("reset_rh_raw", {16'd0, rh_raw}, 0);
      chk("reset_i2c_start", {31'd0, i2c_start}, 0);
      chk("reset_i2c_rw", {31'd0, i2c_rw}, 0);
      chk("reset_tx_byte", {24'd0, i2c_tx_byte}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_start_after_reset_release", {31'd0, i2c_start}, 0);

      s = '0; s.wr_dly = 3; s.n_rx = 6;
      s.b = {8'h5A, 8'h92, 8'hEF, 8'hBE, 8'h92, 8'hEF, 8'hBE};
      run_txn(s);
      s.b[2] = 8'h93;
      run_txn(s);
      s = good(16'h1234, 16'h5678); s.b[5] = s.b[5] ^ 8'h01;
      run_txn(s);
      s = good(16'h1111, 16'h2222); s.wr_nack = 1'b1;
      run_txn(s);
      s = good(16'h3333, 16'h4444); s.n_rx = 4;
      run_txn(s);
      s = good(16'hA5A5, 16'h0F0F); s.n_rx = 7; s.b[6] = 8'hFF;
      run_txn(s);
      s = good(16'h6655, 16'h7788); s.same_cyc = 1'b1;
      run_txn(s);
      s = good(16'h9999, 16'hAAAA); s.n_rx = 5; s.same_cyc = 1'b1;
      run_txn(s);
      s = good(16'hBBBB, 16'hCCCC); s.wr_hold = 1'b1;
      run_txn(s);
      s = good(16'hDDDD, 16'hEEEE); s.rd_hold = 1'b1;
      run_txn(s);
      s = good(16'h0102, 16'h0304); s.rd_nack = 1'b1;
      run_txn(s);
      s = good(16'h4321, 16'h8765); s.wr_dly = T - 1;
      run_txn(s);
      s = good(16'hCAFE, 16'hF00D); s.busy_poke = 1'b1;
      run_txn(s);
      s = good(16'h0BAD, 16'h0DAD); s.b[5] = s.b[5] ^ 8'h80;
      run_txn(s);
      reset_mid_conv();

      for (int n = 0; n < 12; n++) begin
         s = good(16'($urandom), 16'($urandom));
         s.wr_dly = $urandom_range(1, 25);
         s.b[6] = 8'($urandom);
         case ($urandom_range(0, 9))
            0: s.b[2] = s.b[2] ^ 8'(1 << $urandom_range(0, 7));
            1: s.b[5] = s.b[5] ^ 8'(1 << $urandom_range(0, 7));
            2: s.n_rx = $urandom_range(0, 5);
            3: s.n_rx = 7;
            4: s.wr_nack = 1'b1;
            5: s.rd_nack = 1'b1;
            default: ;
         endcase
         s.same_cyc = 1'($urandom_range(0, 1));
         s.busy_poke = ($urandom_range(0, 3) == 0);
         run_txn(s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
